vga_char_pic: RTL and testbench

VGA_CHAR_PIC -- requirements
Module: vga_char_pic

---
 rtl/vga_char_pkg.sv | 21 ++
 rtl/char_rom.sv | 48 ++++
 rtl/vga_char_pic.sv | 117 +++++++++++
 tb/tb_vga_char_pic.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_char_pkg.sv
// Shared constants for the bouncing text-box renderer: screen geometry, box
// geometry, motion bounds and default RGB565 colors.
package vga_char_pkg;

  localparam int unsigned H_VALID = 640;
  localparam int unsigned V_VALID = 480;
  localparam int unsigned BOX_W   = 128;
  localparam int unsigned BOX_H   = 32;
  localparam int unsigned X_MAX   = 512;
  localparam int unsigned Y_MAX   = 448;

  localparam int unsigned ROM_AW  = 7;

  localparam logic [15:0] COLOR_WHITE = 16'hFFFF;
  localparam logic [15:0] COLOR_BLUE  = 16'h001F;
  localparam logic [15:0] COLOR_BLACK = 16'h0000;

  // Coordinate value the timing controller uses for "no pixel requested".
  localparam logic [9:0]  PIX_NONE    = 10'h3FF;

endpackage

// File: rtl/char_rom.sv
// Combinational 128x8 font ROM: 8 glyphs of 16 rows, bit 7 is the leftmost pixel.
// Glyphs: frame, H, E, L, L, O, !, checkerboard.
module char_rom
  import vga_char_pkg::*;
(
  input  logic [ROM_AW-1:0] i_addr,
  output logic [7:0]        o_data
);

  logic [2:0] w_glyph;
  logic [3:0] w_row;
  logic       w_body;

  assign w_glyph = i_addr[6:4];
  assign w_row   = i_addr[3:0];
  assign w_body  = (w_row >= 4'd2) && (w_row <= 4'd13);

  always_comb begin
    o_data = 8'h00;
    unique case (w_glyph)
      3'd0: o_data = ((w_row == 4'd0) || (w_row == 4'd15)) ? 8'hFF : 8'h81;
      3'd1: begin
        if (w_body) o_data = ((w_row == 4'd7) || (w_row == 4'd8)) ? 8'h7E : 8'h42;
      end
      3'd2: begin
        if (w_body) begin
          o_data = ((w_row == 4'd2) || (w_row == 4'd7) || (w_row == 4'd13)) ? 8'h7E : 8'h40;
        end
      end
      3'd3, 3'd4: begin
        if (w_row == 4'd13) o_data = 8'h7E;
        else if (w_body)    o_data = 8'h40;
      end
      3'd5: begin
        if ((w_row == 4'd2) || (w_row == 4'd13)) o_data = 8'h3C;
        else if (w_body)                         o_data = 8'h42;
      end
      3'd6: begin
        if (((w_row >= 4'd2) && (w_row <= 4'd10)) || (w_row == 4'd12) || (w_row == 4'd13)) begin
          o_data = 8'h18;
        end
      end
      3'd7: o_data = w_row[0] ? 8'h55 : 8'hAA;
      default: o_data = 8'h00;
    endcase
  end

endmodule

// File: rtl/vga_char_pic.sv
// Renders a 128x32 text box (2x-scaled 8x16 font) that bounces around a
// 640x480 screen, stepping one pixel per frame; output is one cycle late.
module vga_char_pic
  import vga_char_pkg::*;
#(
  parameter logic [15:0] FG_COLOR  = COLOR_WHITE,
  parameter logic [15:0] BOX_COLOR = COLOR_BLUE,
  parameter logic [15:0] BG_COLOR  = COLOR_BLACK
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic        move_en,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [15:0] pix_data
);

  logic [9:0]  r_box_x;
  logic [8:0]  r_box_y;
  logic        r_dir_x;
  logic        r_dir_y;
  logic [15:0] r_pix_data;

  logic [9:0]  w_box_x_nxt;
  logic [8:0]  w_box_y_nxt;
  logic        w_dir_x_nxt;
  logic        w_dir_y_nxt;
  logic [15:0] w_pix_nxt;

  logic        w_eof;
  logic        w_valid;
  logic        w_hit;
  logic        w_fg;
  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic [2:0]  w_col;
  logic [6:0]  w_rom_addr;
  logic [7:0]  w_rom_data;

  assign w_eof   = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
  assign w_valid = (pix_x != PIX_NONE) && (pix_y != PIX_NONE);

  // Coordinates left of/above the box wrap to large values and fail the bound.
  assign w_dx  = {1'b0, pix_x} - {1'b0, r_box_x};
  assign w_dy  = {1'b0, pix_y} - {2'b00, r_box_y};
  assign w_hit = (w_dx < 11'(BOX_W)) && (w_dy < 11'(BOX_H));

  assign w_col      = w_dx[3:1];
  assign w_rom_addr = {w_dx[6:4], w_dy[4:1]};
  assign w_fg       = w_rom_data[3'd7 - w_col];

  char_rom u_char_rom (
    .i_addr (w_rom_addr),
    .o_data (w_rom_data)
  );

  always_comb begin
    w_pix_nxt = 16'h0000;
    if (w_valid) begin
      if (!w_hit)    w_pix_nxt = BG_COLOR;
      else if (w_fg) w_pix_nxt = FG_COLOR;
      else           w_pix_nxt = BOX_COLOR;
    end
  end

  always_comb begin
    w_box_x_nxt = r_box_x;
    w_box_y_nxt = r_box_y;
    w_dir_x_nxt = r_dir_x;
    w_dir_y_nxt = r_dir_y;
    if (w_eof && move_en) begin
      if (r_dir_x && (r_box_x == 10'(X_MAX))) begin
        w_dir_x_nxt = 1'b0;
        w_box_x_nxt = 10'(X_MAX - 1);
      end else if (!r_dir_x && (r_box_x == 10'd0)) begin
        w_dir_x_nxt = 1'b1;
        w_box_x_nxt = 10'd1;
      end else if (r_dir_x) begin
        w_box_x_nxt = r_box_x + 10'd1;
      end else begin
        w_box_x_nxt = r_box_x - 10'd1;
      end

      if (r_dir_y && (r_box_y == 9'(Y_MAX))) begin
        w_dir_y_nxt = 1'b0;
        w_box_y_nxt = 9'(Y_MAX - 1);
      end else if (!r_dir_y && (r_box_y == 9'd0)) begin
        w_dir_y_nxt = 1'b1;
        w_box_y_nxt = 9'd1;
      end else if (r_dir_y) begin
        w_box_y_nxt = r_box_y + 9'd1;
      end else begin
        w_box_y_nxt = r_box_y - 9'd1;
      end
    end
  end

  // The pixel registered on the eof cycle was computed from the old position.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_data <= 16'h0000;
      r_box_x    <= 10'd0;
      r_box_y    <= 9'd0;
      r_dir_x    <= 1'b1;
      r_dir_y    <= 1'b1;
    end else begin
      r_pix_data <= w_pix_nxt;
      r_box_x    <= w_box_x_nxt;
      r_box_y    <= w_box_y_nxt;
      r_dir_x    <= w_dir_x_nxt;
      r_dir_y    <= w_dir_y_nxt;
    end
  end

  assign pix_data = r_pix_data;

endmodule

// File: tb/tb_vga_char_pic.sv
// Directed bench for vga_char_pic: glyph lookup, invalid requests, box motion,
// bounces, freeze and mid-frame reset, all inferred from pix_data.
module tb_vga_char_pic;

  localparam logic [15:0] FG  = 16'hFFFF;
  localparam logic [15:0] BOX = 16'h001F;
  localparam logic [15:0] BG  = 16'h0000;

  logic        vga_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        move_en = 1'b0;
  logic [9:0]  pix_x   = 10'h3FF;
  logic [9:0]  pix_y   = 10'h3FF;
  logic [15:0] pix_data;

  int checks = 0;
  int errors = 0;

  always #20 vga_clk = ~vga_clk;

  vga_char_pic dut (
    .vga_clk  (vga_clk),
    .rst_n    (rst_n),
    .move_en  (move_en),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_data (pix_data)
  );

  // One request cycle; inputs return to idle before sampling, so the sampled
  // value can only be the registered result of this request.
  task automatic probe(input int x, input int y, output logic [15:0] v);
    @(negedge vga_clk);
    pix_x = 10'(x);
    pix_y = 10'(y);
    @(posedge vga_clk);
    #1;
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
    #1;
    v = pix_data;
  endtask

  task automatic eofs(input int n);
    logic [15:0] v;
    repeat (n) probe(639, 479, v);
  endtask

  // Probe points that pin the box top-left corner to exactly (bx, by).
  task automatic fill_box(input int bx, input int by, output int px[5], output int py[5],
                          output logic [15:0] pe[5]);
    px[0] = bx;       py[0] = by;     pe[0] = FG;
    px[1] = bx - 1;   py[1] = by;     pe[1] = BG;
    px[2] = bx;       py[2] = by - 1; pe[2] = BG;
    px[3] = bx + 127; py[3] = by;     pe[3] = BOX;
    px[4] = bx + 2;   py[4] = by + 2; pe[4] = BOX;
  endtask

  task automatic test_reset;
    pix_x = 10'd0;
    pix_y = 10'd0;
    repeat (2) @(posedge vga_clk);
    #1;
    checks++;
    if (pix_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_hold: got %h want %h", pix_data, 16'h0000);
    end
    @(negedge vga_clk);
    rst_n = 1'b1;
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
  endtask

  task automatic test_glyph;
    int          px[7] = '{0, 2, 16, 18, 127, 127, 1};
    int          py[7] = '{0, 2, 4, 4, 31, 0, 0};
    logic [15:0] pe[7] = '{FG, BOX, BOX, FG, FG, BOX, FG};
    logic [15:0] v;
    for (int i = 0; i < 7; i++) begin
      probe(px[i], py[i], v);
      checks++;
      if (v !== pe[i]) begin
        errors++;
        $display("FAIL glyph(%0d,%0d): got %h want %h", px[i], py[i], v, pe[i]);
      end
    end
  endtask

  task automatic test_invalid;
    int          px[7] = '{0, 1023, 0, 0, 200, 128, 0};
    int          py[7] = '{0, 0, 0, 1023, 100, 0, 32};
    logic [15:0] pe[7] = '{FG, 16'h0000, FG, 16'h0000, BG, BG, BG};
    logic [15:0] v;
    for (int i = 0; i < 7; i++) begin
      probe(px[i], py[i], v);
      checks++;
      if (v !== pe[i]) begin
        errors++;
        $display("FAIL invalid(%0d,%0d): got %h want %h", px[i], py[i], v, pe[i]);
      end
    end
  endtask

  task automatic test_box_at(input string tag, input int bx, input int by);
    int          px[5];
    int          py[5];
    logic [15:0] pe[5];
    logic [15:0] v;
    fill_box(bx, by, px, py, pe);
    for (int i = 0; i < 5; i++) begin
      probe(px[i], py[i], v);
      checks++;
      if (v !== pe[i]) begin
        errors++;
        $display("FAIL %s box(%0d,%0d) probe(%0d,%0d): got %h want %h",
                 tag, bx, by, px[i], py[i], v, pe[i]);
      end
    end
  endtask

  task automatic test_move;
    move_en = 1'b1;
    eofs(5);
    test_box_at("move5", 5, 5);
  endtask

  task automatic test_bounce;
    eofs(443);
    test_box_at("y_top", 448, 448);
    eofs(1);
    test_box_at("y_bounce", 449, 447);
    eofs(63);
    test_box_at("x_top", 512, 384);
    eofs(1);
    test_box_at("x_bounce", 511, 383);
  endtask

  task automatic test_freeze;
    move_en = 1'b0;
    eofs(3);
    test_box_at("freeze", 511, 383);
  endtask

  task automatic test_reset_mid;
    int          px[3] = '{0, 127, 128};
    int          py[3] = '{0, 0, 0};
    logic [15:0] pe[3] = '{FG, BOX, BG};
    logic [15:0] v;
    @(negedge vga_clk);
    rst_n = 1'b0;
    @(negedge vga_clk);
    rst_n   = 1'b1;
    move_en = 1'b1;
    eofs(37);
    test_box_at("pre_reset", 37, 37);
    @(negedge vga_clk);
    pix_x = 10'd37;
    pix_y = 10'd37;
    @(posedge vga_clk);
    #1;
    checks++;
    if (pix_data !== FG) begin
      errors++;
      $display("FAIL pre_reset_pix: got %h want %h", pix_data, FG);
    end
    // Eof request pending when reset hits; it must be discarded.
    pix_x = 10'd639;
    pix_y = 10'd479;
    #5;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pix_data !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset_pix: got %h want %h", pix_data, 16'h0000);
    end
    @(posedge vga_clk);
    #1;
    checks++;
    if (pix_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_edge_pix: got %h want %h", pix_data, 16'h0000);
    end
    @(negedge vga_clk);
    pix_x   = 10'h3FF;
    pix_y   = 10'h3FF;
    move_en = 1'b0;
    rst_n   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      probe(px[i], py[i], v);
      checks++;
      if (v !== pe[i]) begin
        errors++;
        $display("FAIL post_reset(%0d,%0d): got %h want %h", px[i], py[i], v, pe[i]);
      end
    end
    move_en = 1'b1;
    eofs(1);
    test_box_at("dir_after_reset", 1, 1);
  endtask

  task automatic test_back_to_back;
    logic [15:0] v0;
    logic [15:0] v1;
    logic [15:0] v2;
    probe(639, 479, v0);
    probe(2, 1, v1);
    probe(3, 3, v2);
    move_en = 1'b0;
    checks++;
    if (v0 !== BG) begin
      errors++;
      $display("FAIL eof_pixel: got %h want %h", v0, BG);
    end
    checks++;
    if (v1 !== BG) begin
      errors++;
      $display("FAIL new_pos_outside(2,1): got %h want %h", v1, BG);
    end
    checks++;
    if (v2 !== FG) begin
      errors++;
      $display("FAIL new_pos_corner(3,3): got %h want %h", v2, FG);
    end
  endtask

  initial begin
    test_reset();
    test_glyph();
    test_invalid();
    test_move();
    test_bounce();
    test_freeze();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
